// File: rtl/tile_hit_judge_if.sv
// Port bundle for the rhythm-game tile judge: player/sequencer inputs and
// registered judgement/score outputs.
interface tile_hit_judge_if;
    // No valid/ready pair: every input is sampled on each rising Clk edge and
    // every output is a registered level or a one-cycle pulse.
    logic       restart;
    logic       tick;
    logic [3:0] spawn;
    logic [3:0] key;
    logic [3:0] hit_vec;
    logic [3:0] miss_vec;
    logic [15:0] score;
    logic [7:0] combo;
    logic [7:0] miss_count;
    logic       game_over;
    logic       overflow;
    logic       state_dbg;

    modport master (
        output restart, tick, spawn, key,
        input  hit_vec, miss_vec, score, combo, miss_count, game_over, overflow, state_dbg
    );

    modport slave (
        input  restart, tick, spawn, key,
        output hit_vec, miss_vec, score, combo, miss_count, game_over, overflow, state_dbg
    );
endinterface

// File: rtl/tile_hit_judge.sv
// Four-lane tile judge: per-lane age queues, key edge judging, expiry misses,
// score/combo/miss counters and a play/over game FSM.
module tile_hit_judge #(
    parameter int TRAVEL   = 16,
    parameter int WINDOW   = 2,
    parameter int MAX_MISS = 3,
    parameter int QDEPTH   = 4
) (
    input logic           Clk,
    input logic           Reset_n,
    tile_hit_judge_if.slave bus
);
    localparam int LANES = 4;
    localparam int CW = $clog2(QDEPTH + 1);
    localparam logic [5:0] AGE_LO  = 6'(TRAVEL - WINDOW);
    localparam logic [5:0] AGE_HI  = 6'(TRAVEL + WINDOW);
    localparam logic [5:0] AGE_MAX = 6'd63;

    typedef enum logic {ST_PLAY = 1'b0, ST_OVER = 1'b1} state_t;

    state_t        state_q, state_d;
    logic [5:0]    age_q [LANES][QDEPTH];
    logic [5:0]    age_d [LANES][QDEPTH];
    logic [5:0]    shifted [LANES][QDEPTH];
    logic [CW-1:0] cnt_q [LANES];
    logic [CW-1:0] cnt_d [LANES];
    logic [CW-1:0] cnt_popped [LANES];
    logic [3:0]    key_prev_q, key_prev_d;
    logic [3:0]    armed_q, armed_d;
    logic [3:0]    hit_q, hit_d, miss_q, miss_d;
    logic [3:0]    press, pop;
    logic          overflow_q, overflow_d;
    logic [15:0]   score_q, score_d;
    logic [7:0]    combo_q, combo_d, miss_cnt_q, miss_cnt_d;
    logic [2:0]    hits, misses;
    logic [16:0]   score_sum;
    logic [8:0]    combo_sum, miss_sum;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    // A press needs the key to have been seen low since reset, so a key held
    // through reset does not register as a fresh edge on release.
    always_comb begin
        hit_d  = '0;
        miss_d = '0;
        pop    = '0;
        press  = bus.key & ~key_prev_q & armed_q;
        if (state_q == ST_PLAY) begin
            for (int l = 0; l < LANES; l++) begin
                if (cnt_q[l] != '0 && age_q[l][0] > AGE_HI) begin
                    miss_d[l] = 1'b1;
                    pop[l]    = 1'b1;
                end else if (press[l]) begin
                    if (cnt_q[l] != '0 && age_q[l][0] >= AGE_LO) begin
                        hit_d[l] = 1'b1;
                        pop[l]   = 1'b1;
                    end else begin
                        miss_d[l] = 1'b1;
                    end
                end
            end
        end
    end

    // Slots at or beyond the count are kept at zero, so a push simply bumps the count.
    always_comb begin
        age_d      = age_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        key_prev_d = key_prev_q;
        armed_d    = armed_q;
        for (int l = 0; l < LANES; l++) begin
            for (int j = 0; j < QDEPTH - 1; j++) begin
                shifted[l][j] = pop[l] ? age_q[l][j+1] : age_q[l][j];
            end
            shifted[l][QDEPTH-1] = pop[l] ? '0 : age_q[l][QDEPTH-1];
            cnt_popped[l] = cnt_q[l] - CW'(pop[l]);
        end
        if (state_q == ST_PLAY) begin
            key_prev_d = bus.key;
            armed_d    = armed_q | ~bus.key;
            for (int l = 0; l < LANES; l++) begin
                for (int j = 0; j < QDEPTH; j++) begin
                    if (CW'(j) < cnt_popped[l]) begin
                        age_d[l][j] = (bus.tick && shifted[l][j] != AGE_MAX) ?
                                      shifted[l][j] + 6'd1 : shifted[l][j];
                    end else begin
                        age_d[l][j] = '0;
                    end
                end
                cnt_d[l] = cnt_popped[l];
                if (bus.spawn[l]) begin
                    if (cnt_popped[l] < CW'(QDEPTH)) begin
                        cnt_d[l] = cnt_popped[l] + CW'(1);
                    end else begin
                        overflow_d = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        hits      = popcount4(hit_d);
        misses    = popcount4(miss_d);
        score_sum = {1'b0, score_q} + 17'(hits);
        combo_sum = {1'b0, combo_q} + 9'(hits);
        miss_sum  = {1'b0, miss_cnt_q} + 9'(misses);
        score_d    = score_sum[16] ? 16'hFFFF : score_sum[15:0];
        miss_cnt_d = miss_sum[8] ? 8'hFF : miss_sum[7:0];
        if (miss_d != '0) begin
            combo_d = '0;
        end else begin
            combo_d = combo_sum[8] ? 8'hFF : combo_sum[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_PLAY: if (miss_cnt_d >= 8'(MAX_MISS)) state_d = ST_OVER;
            ST_OVER: state_d = ST_OVER;
            default: state_d = ST_PLAY;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_PLAY;
            for (int l = 0; l < LANES; l++) begin
                cnt_q[l] <= '0;
                for (int j = 0; j < QDEPTH; j++) age_q[l][j] <= '0;
            end
            key_prev_q <= '0;
            armed_q    <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
            overflow_q <= 1'b0;
            score_q    <= '0;
            combo_q    <= '0;
            miss_cnt_q <= '0;
        end else if (bus.restart) begin
            state_q    <= ST_PLAY;
            for (int l = 0; l < LANES; l++) begin
                cnt_q[l] <= '0;
                for (int j = 0; j < QDEPTH; j++) age_q[l][j] <= '0;
            end
            key_prev_q <= '0;
            armed_q    <= '0;
            hit_q      <= '0;
            miss_q     <= '0;
            overflow_q <= 1'b0;
            score_q    <= '0;
            combo_q    <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            age_q      <= age_d;
            cnt_q      <= cnt_d;
            key_prev_q <= key_prev_d;
            armed_q    <= armed_d;
            hit_q      <= hit_d;
            miss_q     <= miss_d;
            overflow_q <= overflow_d;
            score_q    <= score_d;
            combo_q    <= combo_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign bus.hit_vec    = hit_q;
    assign bus.miss_vec   = miss_q;
    assign bus.score      = score_q;
    assign bus.combo      = combo_q;
    assign bus.miss_count = miss_cnt_q;
    assign bus.overflow   = overflow_q;
    assign bus.game_over  = (state_q == ST_OVER);
    assign bus.state_dbg  = state_q;
endmodule

// File: tb/tb_tile_hit_judge.sv
// Bench for tile_hit_judge: directed game scenarios plus random play, checked
// every cycle against a queue-based reference model.
module tb_tile_hit_judge;
    localparam int TRAVEL = 16, WINDOW = 2, MAX_MISS = 3, QDEPTH = 4;
    localparam int EW = 42;

    logic Clk;
    logic Reset_n;
    tile_hit_judge_if bus();

    tile_hit_judge #(.TRAVEL(TRAVEL), .WINDOW(WINDOW), .MAX_MISS(MAX_MISS), .QDEPTH(QDEPTH))
        dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    int       lane_q [4][$];
    logic [3:0] m_prev, m_armed, m_hit, m_miss;
    int       m_score, m_combo, m_mc;
    bit       m_go, m_ovf;

    int checks = 0;
    int errors = 0;
    logic [EW-1:0] exp_q [$];
    logic [EW-1:0] exp_cur;
    bit mon_en = 0;

    task automatic model_clear();
        for (int l = 0; l < 4; l++) lane_q[l].delete();
        m_prev = '0; m_armed = '0; m_hit = '0; m_miss = '0;
        m_score = 0; m_combo = 0; m_mc = 0; m_go = 0; m_ovf = 0;
    endtask

    function automatic bit head_in_window(int l);
        if (lane_q[l].size() == 0) return 0;
        return lane_q[l][0] >= TRAVEL - WINDOW && lane_q[l][0] <= TRAVEL + WINDOW;
    endfunction

    task automatic model_step(input bit clr, input bit tk, input logic [3:0] sp, input logic [3:0] ky);
        int hits, misses;
        bit press, do_pop;
        if (clr) begin
            model_clear();
            return;
        end
        m_hit = '0;
        m_miss = '0;
        if (m_go) return;
        for (int l = 0; l < 4; l++) begin
            press  = ky[l] && !m_prev[l] && m_armed[l];
            do_pop = 0;
            if (lane_q[l].size() > 0 && lane_q[l][0] > TRAVEL + WINDOW) begin
                m_miss[l] = 1'b1;
                do_pop = 1;
            end else if (press) begin
                if (head_in_window(l)) begin
                    m_hit[l] = 1'b1;
                    do_pop = 1;
                end else begin
                    m_miss[l] = 1'b1;
                end
            end
            if (do_pop) void'(lane_q[l].pop_front());
            if (tk) begin
                for (int j = 0; j < lane_q[l].size(); j++)
                    if (lane_q[l][j] < 63) lane_q[l][j] = lane_q[l][j] + 1;
            end
            if (sp[l]) begin
                if (lane_q[l].size() < QDEPTH) lane_q[l].push_back(0);
                else m_ovf = 1;
            end
        end
        m_armed = m_armed | ~ky;
        m_prev  = ky;
        hits    = $countones(m_hit);
        misses  = $countones(m_miss);
        m_score = (m_score + hits > 65535) ? 65535 : m_score + hits;
        if (misses > 0) m_combo = 0;
        else m_combo = (m_combo + hits > 255) ? 255 : m_combo + hits;
        m_mc = (m_mc + misses > 255) ? 255 : m_mc + misses;
        if (m_mc >= MAX_MISS) m_go = 1;
    endtask

    function automatic logic [EW-1:0] pack_exp();
        return {m_hit, m_miss, 16'(m_score), 8'(m_combo), 8'(m_mc), m_go, m_ovf};
    endfunction

    function automatic logic [EW-1:0] pack_dut();
        return {bus.hit_vec, bus.miss_vec, bus.score, bus.combo, bus.miss_count,
                bus.game_over, bus.overflow};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit rs, input bit tk, input logic [3:0] sp, input logic [3:0] ky);
        bus.restart = rs;
        bus.tick    = tk;
        bus.spawn   = sp;
        bus.key     = ky;
        model_step(rs || !Reset_n, tk, sp, ky);
        exp_q.push_back(pack_exp());
        @(negedge Clk);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(posedge Clk) begin
        #1;
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: DUT output with no expected entry (t=%0t)", $time);
            end else begin
                exp_cur = exp_q.pop_front();
                chk("outputs{hit,miss,score,combo,mc,go,ovf}", 64'(pack_dut()), 64'(exp_cur));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] ky, sp;
        bit rs, tk;
        Reset_n = 1'b0;
        bus.restart = 1'b0; bus.tick = 1'b0; bus.spawn = '0; bus.key = '0;
        model_clear();
        repeat (2) @(negedge Clk);
        chk("reset_state", 64'(pack_dut()), 64'd0);
        Reset_n = 1'b1;
        mon_en = 1;

        // single hit at exactly TRAVEL
        cycle(0, 0, 4'b0001, 4'b0000);
        repeat (16) cycle(0, 1, 4'b0000, 4'b0000);
        cycle(0, 0, 4'b0000, 4'b0001);
        chk("r037_hit_vec", bus.hit_vec, 4'b0001);
        chk("r037_score", bus.score, 1);
        chk("r037_combo", bus.combo, 1);
        cycle(0, 0, 4'b0000, 4'b0000);
        chk("r037_pulse_one_cycle", bus.hit_vec, 4'b0000);

        // early press miss, then expiry miss
        cycle(0, 0, 4'b0010, 4'b0000);
        repeat (10) cycle(0, 1, 4'b0000, 4'b0000);
        cycle(0, 0, 4'b0000, 4'b0010);
        chk("r038_early_miss_vec", bus.miss_vec, 4'b0010);
        chk("r038_miss_count1", bus.miss_count, 1);
        chk("r038_combo_cleared", bus.combo, 0);
        cycle(0, 0, 4'b0000, 4'b0000);
        repeat (9) cycle(0, 1, 4'b0000, 4'b0000);
        chk("r038_no_miss_at_18", bus.miss_vec, 4'b0000);
        cycle(0, 0, 4'b0000, 4'b0000);
        chk("r038_expiry_miss_vec", bus.miss_vec, 4'b0010);
        chk("r038_miss_count2", bus.miss_count, 2);
        cycle(1, 0, 4'b0000, 4'b0000);
        chk("restart_clears", 64'(pack_dut()), 64'd0);

        // overflow on a full lane, then drain exactly QDEPTH tiles
        repeat (4) cycle(0, 0, 4'b0100, 4'b0000);
        chk("r039_no_overflow_at_4", bus.overflow, 0);
        cycle(0, 0, 4'b0100, 4'b0000);
        chk("r039_overflow", bus.overflow, 1);
        repeat (16) cycle(0, 1, 4'b0000, 4'b0000);
        for (int k = 0; k < 4; k++) begin
            cycle(0, 0, 4'b0000, 4'b0100);
            chk("r039_drain_hit", bus.hit_vec, 4'b0100);
            cycle(0, 0, 4'b0000, 4'b0000);
        end
        cycle(0, 0, 4'b0000, 4'b0100);
        chk("r039_fifth_dropped", bus.miss_vec, 4'b0100);
        cycle(0, 0, 4'b0000, 4'b0000);
        cycle(1, 0, 4'b0000, 4'b0000);

        // two lanes hit together at age 15
        cycle(0, 0, 4'b1001, 4'b0000);
        repeat (15) cycle(0, 1, 4'b0000, 4'b0000);
        cycle(0, 0, 4'b0000, 4'b1001);
        chk("r040_hit_vec", bus.hit_vec, 4'b1001);
        chk("r040_score", bus.score, 2);
        chk("r040_combo", bus.combo, 2);
        cycle(0, 0, 4'b0000, 4'b0000);

        // three simultaneous misses end the game; inputs then ignored
        cycle(0, 0, 4'b0000, 4'b0111);
        chk("r041_miss_vec", bus.miss_vec, 4'b0111);
        chk("r041_miss_count", bus.miss_count, 3);
        chk("r041_game_over", bus.game_over, 1);
        for (int k = 0; k < 20; k++)
            cycle(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        chk("r041_frozen_score", bus.score, 2);
        chk("r041_frozen_mc", bus.miss_count, 3);
        cycle(1, 1, 4'b1111, 4'b1111);
        chk("r041_restart_all_zero", 64'(pack_dut()), 64'd0);
        cycle(0, 0, 4'b0000, 4'b0000);

        // async reset with tiles queued and keys held
        cycle(0, 0, 4'b0011, 4'b0000);
        repeat (16) cycle(0, 1, 4'b0000, 4'b0000);
        Reset_n = 1'b0;
        bus.key = 4'b1111;
        model_clear();
        #1;
        chk("r042_async_clear", 64'(pack_dut()), 64'd0);
        repeat (2) cycle(0, 1, 4'b0000, 4'b1111);
        Reset_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            cycle(0, 1, 4'b0000, 4'b1111);
            chk("r042_no_pulse", {bus.hit_vec, bus.miss_vec}, 8'h00);
        end
        cycle(0, 0, 4'b0001, 4'b1110);
        repeat (16) cycle(0, 1, 4'b0000, 4'b1110);
        cycle(0, 0, 4'b0000, 4'b1111);
        chk("r042_fresh_edge_hit", bus.hit_vec, 4'b0001);

        // random play
        cycle(1, 0, 4'b0000, 4'b0000);
        for (int n = 0; n < 3000; n++) begin
            rs = m_go && ($urandom_range(0, 7) == 0);
            tk = 1'($urandom_range(0, 1));
            for (int l = 0; l < 4; l++) begin
                sp[l] = ($urandom_range(0, 11) == 0);
                if (head_in_window(l)) ky[l] = ($urandom_range(0, 2) == 0);
                else ky[l] = ($urandom_range(0, 15) == 0);
            end
            cycle(rs, tk, sp, ky);
        end

        mon_en = 0;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tile_hit_judge.md
TILE_HIT_JUDGE -- requirements
Module: tile_hit_judge

Interface
REQ-001 Parameter TRAVEL, default 16, tick count from tile spawn to hit line.
REQ-002 Parameter WINDOW, default 2, ± tick tolerance around TRAVEL for a valid hit.
REQ-003 Parameter MAX_MISS, default 3, miss count that ends the game.
REQ-004 Parameter QDEPTH, default 4, tiles held per lane.
REQ-005 Clk  input  1  single clock; all state updates on rising edge.
REQ-006 Reset_n  input  1  asynchronous, active-low reset.
REQ-007 restart  input  1  synchronous clear of game state; same effect as reset.
REQ-008 tick  input  1  one-cycle pulse; advances tile ages.
REQ-009 spawn  input  4  one bit per lane, driven by song sequencer note outputs block1..block4 (bit0=block1).
REQ-010 key  input  4  player key levels, one per lane, already synchronised.
REQ-011 hit_vec  output  4  one-cycle pulse per lane on a judged hit.
REQ-012 miss_vec  output  4  one-cycle pulse per lane on a judged miss.
REQ-013 score  output  16  total hits, saturating at 65535.
REQ-014 combo  output  8  consecutive hits since last miss, saturating at 255.
REQ-015 miss_count  output  8  total misses, saturating at 255.
REQ-016 game_over  output  1  level, high once miss_count >= MAX_MISS.
REQ-017 overflow  output  1  sticky, set when a spawn is dropped on a full lane queue.

Function
REQ-018 Each lane SHALL hold an in-order queue of up to QDEPTH tiles, each with a 6-bit age; the oldest tile is the head.
REQ-019 spawn[i] high SHALL push a tile with age 0 into lane i; if lane i is full, the spawn is dropped and overflow set.
REQ-020 On tick, every valid tile age SHALL increment by 1, saturating at 63; TRAVEL+WINDOW < 63 is required.
REQ-021 Key press SHALL be the rising edge of key[i] (registered previous value); held keys do not re-trigger.
REQ-022 Press on lane i with head valid and TRAVEL-WINDOW <= head age <= TRAVEL+WINDOW SHALL pulse hit_vec[i] and pop the head.
REQ-023 Press on lane i with empty queue or head outside window SHALL pulse miss_vec[i] without popping.
REQ-024 Head age > TRAVEL+WINDOW SHALL pulse miss_vec[i] and pop the head (expiry), regardless of key.
REQ-025 Expiry and press on the same lane in the same cycle SHALL count as one miss.
REQ-026 Judging SHALL use ages before any same-cycle tick increment; tick takes effect next cycle.
REQ-027 Push and pop on the same lane in one cycle SHALL both occur; a full queue with a pop accepts the push.
REQ-028 hit_vec/miss_vec SHALL be registered: asserted in the cycle after the judged edge/expiry.
REQ-029 score SHALL increase by popcount(hit_vec) each cycle.
REQ-030 Any miss_vec bit set SHALL clear combo to 0 and add popcount(miss_vec) to miss_count; otherwise combo += popcount(hit_vec).
REQ-031 When miss_count reaches MAX_MISS, game_over SHALL rise in the same cycle miss_count updates.
REQ-032 While game_over, spawns, ticks and keys SHALL be ignored; all counters and queues freeze.
REQ-033 Lanes SHALL be judged independently; simultaneous events on several lanes all take effect in one cycle.

Reset
REQ-034 Reset_n low SHALL asynchronously empty all queues and clear hit_vec, miss_vec, score, combo, miss_count, game_over, overflow, key history to 0.
REQ-035 restart high SHALL produce the same state on the next edge; it overrides all other inputs that cycle.
REQ-036 Reset asserted mid-game SHALL discard pending tiles; no hit/miss pulse follows release.

Verification
REQ-037 spawn=0001, 16 ticks, key[0] rises -> hit_vec=0001 one cycle, score=1, combo=1, queue empty.
REQ-038 spawn=0010, 10 ticks, key[1] rises -> miss_vec=0010, miss_count=1, combo=0, tile stays; after 9 more ticks (age 19) -> expiry miss, miss_count=2.
REQ-039 spawn 5 times on lane 2 with no ticks -> 4 tiles queued, overflow=1, fifth dropped.
REQ-040 tiles on lanes 0 and 3 at age 15, key=1001 rising same cycle -> hit_vec=1001, score +2, combo +2.
REQ-041 three misses -> game_over=1; further spawn/key/tick change nothing; restart -> all outputs 0.
REQ-042 Reset_n pulled low with tiles queued and key held -> outputs 0 immediately; no pulses after release until new spawn and fresh key edge.
